// File: rtl/clock_disp_pkg.sv
// Shared constants for the 7-segment display blocks: the digit decode
// table, blank/dash patterns and the digit slot indices.
package clock_disp_pkg;

  // Decimal digits 0-9 as gfedcba patterns; a segment is lit when its bit is 0.
  localparam logic [6:0] SEG7 [0:9] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Only segment g lit.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit slot indices; each one is also the position of that digit's anode bit.
  localparam logic [1:0] DIG_S1  = 2'd0;
  localparam logic [1:0] DIG_S10 = 2'd1;
  localparam logic [1:0] DIG_M1  = 2'd2;
  localparam logic [1:0] DIG_M10 = 2'd3;

endpackage

// File: rtl/seg7_dec.sv
// Combinational digit-to-segment decoder for an active-low 7-segment display.
// Blank wins over everything else. A value flagged invalid, or any value
// above 9, is shown as a dash.
module seg7_dec
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_valid,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Pick the blank pattern, the dash pattern or the table entry for the digit.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank)
      o_seg = SEG_BLANK;
    else if (!i_valid || (i_val > 4'd9))
      o_seg = SEG_DASH;
    else
      o_seg = SEG7[i_val];
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Drives a 4-digit common-anode multiplexed display from the MM:SS digit bus.
// It scans the digits with a blank gap at the end of each slot, takes a
// tear-free snapshot of the digits once per frame, blinks the minute and
// second fields, blinks the colon and blanks a leading zero in min10.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int HALF_SEC  = 25000000,
  parameter int LZB       = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] sec1,
  input  logic [2:0] sec10,
  input  logic [3:0] min1,
  input  logic [2:0] min10,
  input  logic       EN1HZ,
  input  logic [1:0] BLINK,
  output logic [7:0] SEG,
  output logic [3:0] AN
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(HALF_SEC + 1);

  logic [SW-1:0] r_scnt;
  logic [1:0]    r_dsel;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [3:0]    r_s1;
  logic [2:0]    r_s10;
  logic [3:0]    r_m1;
  logic [2:0]    r_m10;

  logic          w_scnt_wrap;
  logic          w_bcnt_wrap;
  logic          w_active;
  logic [3:0]    w_val;
  logic          w_valid;
  logic          w_fld_blink;
  logic          w_blank;
  logic          w_dp;
  logic [6:0]    w_seg;

  assign w_scnt_wrap = (r_scnt == SW'(SCAN_DIV - 1));
  assign w_bcnt_wrap = (r_bcnt == BW'(HALF_SEC - 1));
  // The last BLANK_CYC cycles of each slot turn every anode off so the
  // previous digit's segments do not ghost onto the next digit.
  assign w_active    = (r_scnt < SW'(SCAN_DIV - BLANK_CYC));

  // Slot counter; each time it wraps, the scan moves on to the next digit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_scnt <= '0;
      r_dsel <= DIG_S1;
    end else if (w_scnt_wrap) begin
      r_scnt <= '0;
      r_dsel <= r_dsel + 2'd1;
    end else begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

  // Capture all four digits at the frame boundary so a frame never mixes old and new time.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1  <= '0;
      r_s10 <= '0;
      r_m1  <= '0;
      r_m10 <= '0;
    end else if (w_scnt_wrap && (r_dsel == DIG_M10)) begin
      r_s1  <= sec1;
      r_s10 <= sec10;
      r_m1  <= min1;
      r_m10 <= min10;
    end
  end

  // Blink phase generator; the 1 Hz tick re-aligns it so the colon lights on the tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (EN1HZ) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_bcnt_wrap) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  // Select the digit for the current slot, check its range and find its blink field.
  always_comb begin
    w_val       = 4'd0;
    w_valid     = 1'b1;
    w_fld_blink = 1'b0;
    unique case (r_dsel)
      DIG_S1: begin
        w_val       = r_s1;
        w_valid     = (r_s1 <= 4'd9);
        w_fld_blink = BLINK[0];
      end
      DIG_S10: begin
        w_val       = {1'b0, r_s10};
        w_valid     = (r_s10 <= 3'd5);
        w_fld_blink = BLINK[0];
      end
      DIG_M1: begin
        w_val       = r_m1;
        w_valid     = (r_m1 <= 4'd9);
        w_fld_blink = BLINK[1];
      end
      DIG_M10: begin
        w_val       = {1'b0, r_m10};
        w_valid     = (r_m10 <= 3'd5);
        w_fld_blink = BLINK[1];
      end
    endcase
  end

  assign w_blank = (w_fld_blink && !r_phase) ||
                   ((LZB != 0) && (r_dsel == DIG_M10) && (r_m10 == 3'd0));
  // The colon is wired to the dp of the min1 digit.
  assign w_dp    = ~((r_dsel == DIG_M1) && r_phase);

  seg7_dec u_dec (
    .i_val   (w_val),
    .i_valid (w_valid),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Register the display pins; every anode is off and every segment is dark during the blank gap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG <= 8'hFF;
      AN  <= 4'hF;
    end else if (w_active) begin
      SEG <= {w_dp, w_seg};
      AN  <= ~(4'b0001 << r_dsel);
    end else begin
      SEG <= 8'hFF;
      AN  <= 4'hF;
    end
  end

endmodule

// File: tb/tb_clock_disp_scan.sv
module tb_clock_disp_scan;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int HS = 10;
  localparam int LZ = 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] sec1 = 4'd0;
  logic [2:0] sec10 = 3'd0;
  logic [3:0] min1 = 4'd0;
  logic [2:0] min10 = 3'd0;
  logic       EN1HZ = 1'b0;
  logic [1:0] BLINK = 2'b00;
  logic [7:0] SEG;
  logic [3:0] AN;

  clock_disp_scan #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .HALF_SEC (HS),
    .LZB      (LZ)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .sec1 (sec1),
    .sec10(sec10),
    .min1 (min1),
    .min10(min10),
    .EN1HZ(EN1HZ),
    .BLINK(BLINK),
    .SEG  (SEG),
    .AN   (AN)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: t = cycles since reset release, k = cycles since the
  // blink anchor (reset or the last 1 Hz tick), snap = digits shown this frame.
  int t = 0;
  int k = 0;
  int snap[4] = '{default: 0};
  int pat[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  function automatic logic [11:0] model_out();
    int slot, pos, v, lim;
    bit ph, blk;
    logic [6:0] g;
    logic dp;
    slot = (t / SD) % 4;
    pos  = t % SD;
    if (pos >= SD - BC) return {4'hF, 8'hFF};
    ph  = ((k / HS) % 2) == 0;
    v   = snap[slot];
    lim = (slot % 2 == 0) ? 9 : 5;
    blk = (BLINK[slot / 2] && !ph) || (LZ != 0 && slot == 3 && v == 0);
    if (blk) g = 7'h7F;
    else if (v > lim) g = 7'h3F;
    else g = 7'(pat[v]);
    dp = !(slot == 2 && ph);
    return {~(4'b0001 << slot), dp, g};
  endfunction

  task automatic step(input string tag);
    logic [11:0] exp;
    exp = model_out();
    @(posedge CLK);
    if (t % (4 * SD) == 4 * SD - 1) begin
      snap[0] = sec1; snap[1] = sec10; snap[2] = min1; snap[3] = min10;
    end
    t++;
    k = EN1HZ ? 0 : k + 1;
    @(negedge CLK);
    n_assert++;
    assert ({AN, SEG} === exp) else begin
      n_fail++;
      $error("FAIL %s: AN/SEG got %h/%h expected %h/%h", tag, AN, SEG, exp[11:8], exp[7:0]);
    end
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b0;
    t = 0; k = 0;
    snap = '{default: 0};
    #1;
    n_assert++;
    assert ({AN, SEG} === 12'hFFF) else begin
      n_fail++;
      $error("FAIL rst_async: AN/SEG got %h/%h expected f/ff", AN, SEG);
    end
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      n_assert++;
      assert ({AN, SEG} === 12'hFFF) else begin
        n_fail++;
        $error("FAIL rst_hold: AN/SEG got %h/%h expected f/ff", AN, SEG);
      end
    end
    RST = 1'b1;
  endtask

  task automatic set_time(input int m10, input int m1, input int s10, input int s1);
    min10 = 3'(m10); min1 = 4'(m1); sec10 = 3'(s10); sec1 = 4'(s1);
  endtask

  initial begin
    #1;
    // Reset with 12:34 on the bus; first frame shows zeros, then 12:34.
    set_time(1, 2, 3, 4);
    do_reset(3);
    steps(16, "frame0");
    step("frame1_s1");
    n_assert++;
    assert ({AN, SEG} === 12'hE99) else begin
      n_fail++;
      $error("FAIL first_s1: AN/SEG got %h/%h expected e/99", AN, SEG);
    end
    // Scan timing over several frames at fixed input.
    steps(47, "scan");

    // Tear-free snapshot: 09:59 -> 10:00 while the sec10 slot is active.
    set_time(0, 9, 5, 9);
    steps(16, "snap_prep");
    steps(16, "snap_0959");
    steps(6, "snap_mid");
    set_time(1, 0, 0, 0);
    steps(26, "snap_1000");

    // Minute field blink, then a 1 Hz tick during the off phase.
    BLINK = 2'b10;
    steps(40, "blink_min");
    while ((k / HS) % 2 == 0) step("blink_seek");
    EN1HZ = 1'b1;
    step("en1hz");
    EN1HZ = 1'b0;
    steps(24, "after_en1hz");
    BLINK = 2'b01;
    steps(30, "blink_sec");
    BLINK = 2'b00;

    // Leading zero blanking and invalid digits.
    set_time(0, 7, 4, 2);
    steps(32, "lzb");
    set_time(3, 7, 4, 12);
    steps(32, "inv_s1");
    set_time(6, 7, 4, 2);
    steps(32, "inv_m10");

    // Randomized stretch.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_time($urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) BLINK = 2'($urandom_range(0, 3));
      EN1HZ = ($urandom_range(0, 29) == 0);
      step("random");
    end
    EN1HZ = 1'b0;

    // Async reset while the min1 slot is lit.
    set_time(1, 2, 3, 4);
    BLINK = 2'b00;
    do_reset(2);
    steps(9, "pre_async");
    n_assert++;
    assert (AN === 4'b1011) else begin
      n_fail++;
      $error("FAIL async_setup: AN got %h expected b", AN);
    end
    do_reset(2);
    step("post_async_first");
    n_assert++;
    assert (AN === 4'b1110) else begin
      n_fail++;
      $error("FAIL post_async_an: AN got %h expected e", AN);
    end
    steps(20, "post_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_disp_scan.md
Name: clock_disp_scan

Overview:
Display-side consumer of the MM:SS digit bus produced by the clock counter block. It snapshots the four BCD digits and drives a 4-digit, common-anode, multiplexed 7-segment display with per-digit anode scanning and anti-ghosting blank gaps. It also provides field blinking for set mode, a colon (dp) blinking in phase with the 1 Hz tick, and leading-zero blanking. It sits between the clock core and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (1 kHz slot rate at 50 MHz); must be >= 2
BLANK_CYC, 2, cycles at the end of each slot with all anodes off; must be < SCAN_DIV
HALF_SEC, 25000000, cycles per blink half-period
LZB, 1, 1 = blank the min10 digit when it is 0

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
sec1  in  4  seconds ones, BCD
sec10  in  3  seconds tens, 0-5
min1  in  4  minutes ones, BCD
min10  in  3  minutes tens, 0-5
EN1HZ  in  1  one-cycle 1 Hz tick from the seconds prescaler
BLINK  in  2  [1]=blink minute field, [0]=blink second field
SEG  out  8  active-low segments; [7]=dp, [6:0]=g..a
AN  out  4  active-low anodes; [0]=sec1, [1]=sec10, [2]=min1, [3]=min10

Behaviour:
- Reset (RST low, async): SEG=8'hFF, AN=4'hF, scnt=0, dsel=0, snapshot=0, bcnt=0, phase=1.
- Slot counter scnt counts 0..SCAN_DIV-1 and wraps. On wrap, dsel increments 0->1->2->3->0.
- Snapshot: all four digit inputs are captured together on the cycle where scnt wraps and dsel goes 3->0, so one frame never mixes old and new digits. The first snapshot after reset is taken at the first such wrap. Until then the snapshot is 0.
- Blink: bcnt counts 0..HALF_SEC-1. phase toggles on each wrap.
  - EN1HZ=1 forces bcnt=0 and phase=1 on the next edge. This overrides a simultaneous wrap.
- Digit enable for slot dsel: active when scnt < SCAN_DIV-BLANK_CYC. Otherwise AN=4'hF and SEG=8'hFF (blank gap).
- Segment value for the active slot:
  - Digit blanked (SEG[6:0]=7'h7F) when:
    - the field's BLINK bit is 1 and phase=0, or
    - LZB=1, dsel=3 and snapshot min10=0.
  - Invalid value (ones >9 or tens >5): dash only, SEG[6:0]=7'b0111111.
  - Otherwise standard hex-free 0-9 decode, gfedcba active-low. Examples: 0=1000000, 1=1111001, 5=0010010, 8=0000000.
  - dp (SEG[7]) is 0 only when dsel=2 and phase=1 (colon after the minutes). Blink masking does not affect dp.
- Registering: AN and SEG are registered. They reflect the scnt/dsel/phase/snapshot of the previous cycle, so latency is 1 cycle. Exactly one AN bit is low during active time, and none during blank gaps.
- BLINK and EN1HZ are used directly; both are already synchronous to CLK.
- RST asserted mid-frame returns everything to the reset values immediately. Scanning restarts at dsel=0, scnt=0.

Decomposition:
- Package clock_disp_pkg holds:
  - the 10-entry SEG7 decode constant array,
  - SEG_BLANK=7'h7F and SEG_DASH=7'b0111111,
  - the digit index constants (DIG_S1=0, DIG_S10=1, DIG_M1=2, DIG_M10=3).
- Sub-module seg7_dec is natural: combinational 4-bit value + valid + blank in, 7-bit active-low pattern out. It is reused by other display blocks.
- Scan/blink counters and output registers stay in the top.

Test Plan:
(Benches use SCAN_DIV=4, BLANK_CYC=1, HALF_SEC=10, LZB=1.)
1. Reset:
   - Stimulus: hold RST low 3 cycles, inputs 12:34.
   - Response: SEG=FF and AN=F throughout. After release, the first frame shows all digits as 0 with min10 blank. After the first 3->0 wrap it shows AN=1110 with SEG[6:0]=0011001 (4), then sec10=3, then min1=2 with dp=0, then min10=1.
2. Scan timing:
   - Stimulus: inputs fixed at 12:34.
   - Response: each AN pattern is low for 3 cycles followed by 1 cycle of AN=F. Sequence 1110, 1101, 1011, 0111 repeats every 16 cycles.
3. Tear-free snapshot:
   - Stimulus: change inputs from 09:59 to 10:00 while dsel=1.
   - Response: the rest of the frame still shows 09:59. The next frame shows 10:00, with min10 showing "1".
4. Blink and EN1HZ:
   - Stimulus: BLINK=2'b10.
   - Response: min digits alternate on/off every 10 cycles while sec digits stay on. An EN1HZ pulse during the off phase makes the min digits and dp visible from the next edge.
5. Invalid and leading zero:
   - Stimulus: min10=0, then sec1=4'd12, then min10=6.
   - Response: min10=0 gives AN=0111 with SEG[6:0]=7F. sec1=12 gives a dash on the sec1 slot. min10=6 gives a dash.
6. Async reset mid-slot:
   - Stimulus: drop RST between edges while AN=1011.
   - Response: AN=F and SEG=FF immediately, without waiting for a clock edge. After release, the first active slot is AN=1110.
